// File: rtl/fifo_rd_stream.sv
// Read-side consumer for fifo_sync: drains words into a 2-entry skid buffer
// and presents them as a valid/ready stream with a delivered-word counter.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   en, flush      read enable; synchronous discard of buffered/in-flight words
//   fifo_empty     fifo_sync empty flag
//   fifo_data_out  fifo_sync registered read data
//   fifo_cs        fifo_sync chip select (same as fifo_rd_en)
//   fifo_rd_en     fifo_sync read request
//   m_valid        output word available
//   m_ready        sink ready
//   m_data         head-of-buffer word
//   rd_count       words delivered to the sink (wraps)
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  logic [1:0]            occ;
  logic                  pend;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic [CNT_WIDTH-1:0]  cnt;

  logic                  pop;
  logic                  cap;
  logic [2:0]            load;
  logic [1:0]            slot;

  assign m_valid  = (occ != 2'd0);
  assign m_data   = head;
  assign rd_count = cnt;

  assign pop = m_valid & m_ready;
  assign cap = pend & ~flush;

  // Words that will still be held after this edge if nothing else arrives;
  // a new read is only safe when at most one slot is spoken for.
  assign load = {1'b0, occ} + {2'b0, pend} - {2'b0, pop};

  // Gated by rst_n so the request drops the instant reset asserts.
  assign fifo_rd_en = rst_n & en & ~flush & ~fifo_empty
                    & (load <= 3'd1);
  assign fifo_cs    = fifo_rd_en;

  // Tail position after the head (possibly) leaves this cycle.
  assign slot = occ - {1'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= 2'd0;
      pend <= 1'b0;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      pend <= fifo_rd_en;
      if (pop)
        cnt <= cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      if (flush) begin
        occ <= 2'd0;
      end else begin
        occ <= occ + {1'b0, cap} - {1'b0, pop};
        if (pop)
          head <= tail;
        // Later assignment wins: a capture into slot 0 overrides the shift.
        if (cap) begin
          if (slot == 2'd0)
            head <= fifo_data_out;
          else
            tail <= fifo_data_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based fifo_sync model plus a scoreboard
// of words read but not yet delivered, checked every cycle.
module tb_fifo_rd_stream;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_cs;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [CW-1:0] rd_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] load_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic          inflight = 1'b0;
  logic [CW-1:0] mcnt = '0;

  int cyc = 0;
  int nreads = 0;
  int first_rd = -1;
  int first_v = -1;
  int total = 0;

  bit            m_acc;
  bit            m_pop;
  logic [DW-1:0] m_w;

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_data_out(fifo_data_out),
    .fifo_cs      (fifo_cs),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .rd_count     (rd_count)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Words read but not yet delivered; the newest may still be in flight.
  function automatic bit model_valid();
    return exp_q.size() > int'(inflight);
  endfunction

  // fifo_sync model plus delivery scoreboard.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q.delete();
      exp_q.delete();
      inflight      <= 1'b0;
      mcnt          <= '0;
      fifo_empty    <= 1'b1;
      fifo_data_out <= '0;
    end else begin
      m_pop = model_valid() && m_ready;
      m_acc = fifo_cs && fifo_rd_en && !fifo_empty && fifo_q.size() > 0;
      if (m_valid && m_ready)
        got_q.push_back(m_data);
      if (m_pop) begin
        void'(exp_q.pop_front());
        mcnt <= mcnt + 1'b1;
      end
      if (flush)
        exp_q.delete();
      if (m_acc) begin
        m_w = fifo_q.pop_front();
        fifo_data_out <= m_w;
        exp_q.push_back(m_w);
      end
      inflight <= m_acc;
      while (load_q.size() > 0)
        fifo_q.push_back(load_q.pop_front());
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  task automatic step();
    bit ev;
    bit er;
    #1;
    ev = model_valid();
    er = en && !flush && !fifo_empty
      && ((exp_q.size() - int'(ev && m_ready)) <= 1);
    chk("m_valid", m_valid, ev);
    if (ev)
      chk("m_data", m_data, exp_q[0]);
    chk("rd_en", fifo_rd_en, er);
    chk("cs", fifo_cs, er);
    chk("rd_count", rd_count, mcnt);
    if (fifo_rd_en) begin
      nreads++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid && first_v < 0) first_v = cyc;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_got(input int n, input int bound);
    int k = 0;
    while (got_q.size() < n && k < bound) begin
      step();
      k++;
    end
    chk("wait_got", got_q.size(), n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    en = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_count", rd_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic stream
    m_ready = 1'b1;
    load_q.push_back(1);
    load_q.push_back(10);
    load_q.push_back(100);
    wait_got(3, 30);
    chk("basic0", got_q[0], 1);
    chk("basic1", got_q[1], 10);
    chk("basic2", got_q[2], 100);
    chk("latency", first_v - first_rd, 2);
    total += 3;
    chk("basic_cnt", rd_count, total % 16);
    step();
    chk("basic_idle", fifo_rd_en, 0);

    // Backpressure
    m_ready = 1'b0;
    got_q.delete();
    for (int i = 0; i < 8; i++) load_q.push_back(1 << i);
    nreads = 0;
    repeat (11) step();
    chk("bp_reads", nreads, 2);
    #1;
    chk("bp_hold", m_data, 1);
    chk("bp_valid", m_valid, 1);
    m_ready = 1'b1;
    n = 0;
    while (got_q.size() < 8 && n < 40) begin
      step();
      n++;
    end
    chk("bp_cycles", n, 8);
    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] e;
      e = 1 << i;
      chk("bp_word", got_q[i], e);
    end
    total += 8;
    chk("bp_cnt", rd_count, total % 16);

    // Toggling ready
    got_q.delete();
    for (int i = 0; i < 8; i++) load_q.push_back(32'h100 + i);
    nreads = 0;
    n = 0;
    while (got_q.size() < 8 && n < 60) begin
      m_ready = ~m_ready;
      step();
      chk("outst", (nreads - got_q.size()) <= 2, 1);
      n++;
    end
    chk("tog_len", got_q.size(), 8);
    for (int i = 0; i < 8; i++) chk("tog_word", got_q[i], 32'h100 + i);
    total += 8;
    chk("tog_cnt", rd_count, total % 16);

    // Flush with two words buffered
    m_ready = 1'b0;
    got_q.delete();
    for (int i = 5; i <= 8; i++) load_q.push_back(i);
    repeat (6) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("fl_valid", m_valid, 0);
    chk("fl_cnt", rd_count, total % 16);
    m_ready = 1'b1;
    wait_got(2, 20);
    chk("fl_next", got_q[0], 7);
    chk("fl_last", got_q[1], 8);
    total += 2;

    // en gating
    en = 1'b0;
    got_q.delete();
    for (int i = 0; i < 3; i++) load_q.push_back(32'h31 + i);
    nreads = 0;
    repeat (6) step();
    chk("en_off", nreads, 0);
    en = 1'b1;
    wait_got(3, 20);
    for (int i = 0; i < 3; i++) chk("en_word", got_q[i], 32'h31 + i);
    total += 3;
    got_q.delete();
    for (int i = 0; i < 4; i++) load_q.push_back(32'h41 + i);
    nreads = 0;
    repeat (3) step();
    chk("en_mid_reads", nreads, 2);
    en = 1'b0;
    nreads = 0;
    repeat (8) step();
    chk("en_drop_reads", nreads, 0);
    chk("en_drop_len", got_q.size(), 2);
    chk("en_drop_w0", got_q[0], 32'h41);
    chk("en_drop_w1", got_q[1], 32'h42);
    en = 1'b1;
    wait_got(4, 20);
    chk("en_rest", got_q[3], 32'h44);
    total += 4;
    chk("en_cnt", rd_count, total % 16);

    // Reset mid-operation with a full buffer
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) load_q.push_back(32'h51 + i);
    repeat (7) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", m_valid, 0);
    chk("mr_rd_en", fifo_rd_en, 0);
    chk("mr_count", rd_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    total = 0;
    load_q.push_back(32'h61);
    load_q.push_back(32'h62);
    m_ready = 1'b1;
    wait_got(2, 20);
    chk("mr_w0", got_q[0], 32'h61);
    chk("mr_w1", got_q[1], 32'h62);
    chk("mr_cnt", rd_count, 2);

    // Random traffic
    repeat (600) begin
      en      = ($urandom % 5) != 0;
      m_ready = ($urandom % 3) != 0;
      flush   = ($urandom % 25) == 0;
      if (($urandom % 3) == 0) load_q.push_back($urandom);
      step();
    end
    en = 1'b1;
    flush = 1'b0;
    m_ready = 1'b1;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || load_q.size() != 0)
           && n < 3000) begin
      step();
      n++;
    end
    step();
    chk("drain_valid", m_valid, 0);
    chk("drain_rd_en", fifo_rd_en, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
